// File: rtl/mbist_err_capture_if.sv
// Bus between the MBIST controller/SRAM side and the error-capture stage.
// The master drives reads and returned data; the slave reports errors and status.
interface mbist_err_capture_if #(
  parameter int unsigned BIST_ADDR_WD = 9,
  parameter int unsigned BIST_DATA_WD = 32
);
  logic                    bist_clear;
  logic                    bist_rd;
  logic [BIST_ADDR_WD-1:0] bist_addr;
  logic [BIST_DATA_WD-1:0] bist_exp_data;
  logic [BIST_DATA_WD-1:0] mem_rdata;
  logic                    Error;
  logic [BIST_ADDR_WD-1:0] ErrorAddr;
  logic [3:0]              err_cnt;
  logic [7:0]              mismatch_cnt;
  logic                    err_seen;
  logic                    bist_fail;

  modport master (
    output bist_clear, bist_rd, bist_addr, bist_exp_data, mem_rdata,
    input  Error, ErrorAddr, err_cnt, mismatch_cnt, err_seen, bist_fail
  );

  modport slave (
    input  bist_clear, bist_rd, bist_addr, bist_exp_data, mem_rdata,
    output Error, ErrorAddr, err_cnt, mismatch_cnt, err_seen, bist_fail
  );
endinterface

// File: rtl/mbist_err_capture.sv
// Aligns BIST reads to SRAM latency, compares returned data and reports each
// new failing address once, up to the spare-row budget, with sticky status.
module mbist_err_capture #(
  parameter int unsigned BIST_ADDR_WD   = 9,
  parameter int unsigned BIST_DATA_WD   = 32,
  parameter int unsigned BIST_RD_LAT    = 1,
  parameter int unsigned BIST_ERR_LIMIT = 4
) (
  input logic                clk,
  input logic                rst_n,
  mbist_err_capture_if.slave bus
);
  localparam int unsigned LAST = BIST_RD_LAT - 1;

  logic [BIST_RD_LAT-1:0]  vld_q, vld_d;
  logic [BIST_ADDR_WD-1:0] addr_q [BIST_RD_LAT];
  logic [BIST_ADDR_WD-1:0] addr_d [BIST_RD_LAT];
  logic [BIST_DATA_WD-1:0] exp_q  [BIST_RD_LAT];
  logic [BIST_DATA_WD-1:0] exp_d  [BIST_RD_LAT];
  logic [BIST_ADDR_WD-1:0] list_q [BIST_ERR_LIMIT];
  logic [BIST_ADDR_WD-1:0] list_d [BIST_ERR_LIMIT];

  logic [3:0]              err_cnt_q, err_cnt_d;
  logic [7:0]              mismatch_cnt_q, mismatch_cnt_d;
  logic                    error_q, error_d;
  logic [BIST_ADDR_WD-1:0] error_addr_q, error_addr_d;
  logic                    err_seen_q, err_seen_d;
  logic                    bist_fail_q, bist_fail_d;

  logic                    mism;
  logic                    hit;
  logic [BIST_ADDR_WD-1:0] addr_out;

  assign addr_out = addr_q[LAST];

  always_comb begin
    vld_d     = vld_q;
    addr_d    = addr_q;
    exp_d     = exp_q;
    vld_d[0]  = bus.bist_rd;
    addr_d[0] = bus.bist_addr;
    exp_d[0]  = bus.bist_exp_data;
    for (int unsigned i = 1; i < BIST_RD_LAT; i++) begin
      vld_d[i]  = vld_q[i-1];
      addr_d[i] = addr_q[i-1];
      exp_d[i]  = exp_q[i-1];
    end
    if (bus.bist_clear) begin
      vld_d = '0;
    end
  end

  always_comb begin
    mism = vld_q[LAST] && (bus.mem_rdata != exp_q[LAST]);
    hit  = 1'b0;
    for (int unsigned i = 0; i < BIST_ERR_LIMIT; i++) begin
      if ((4'(i) < err_cnt_q) && (list_q[i] == addr_out)) begin
        hit = 1'b1;
      end
    end
    hit = hit && mism;
  end

  // The list is written at the same edge the decision registers, so a
  // back-to-back repeat of the same address already sees itself as live.
  always_comb begin
    error_d        = 1'b0;
    error_addr_d   = error_addr_q;
    err_cnt_d      = err_cnt_q;
    list_d         = list_q;
    mismatch_cnt_d = mismatch_cnt_q;
    err_seen_d     = err_seen_q;
    bist_fail_d    = bist_fail_q;
    if (mism) begin
      err_seen_d = 1'b1;
      if (mismatch_cnt_q != 8'hFF) begin
        mismatch_cnt_d = mismatch_cnt_q + 8'd1;
      end
      if (!hit) begin
        if (err_cnt_q < 4'(BIST_ERR_LIMIT)) begin
          error_d      = 1'b1;
          error_addr_d = addr_out;
          err_cnt_d    = err_cnt_q + 4'd1;
          for (int unsigned i = 0; i < BIST_ERR_LIMIT; i++) begin
            if (4'(i) == err_cnt_q) begin
              list_d[i] = addr_out;
            end
          end
        end else begin
          bist_fail_d = 1'b1;
        end
      end
    end
    if (bus.bist_clear) begin
      error_d        = 1'b0;
      error_addr_d   = '0;
      err_cnt_d      = '0;
      list_d         = '{default: '0};
      mismatch_cnt_d = '0;
      err_seen_d     = 1'b0;
      bist_fail_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q          <= '0;
      addr_q         <= '{default: '0};
      exp_q          <= '{default: '0};
      list_q         <= '{default: '0};
      err_cnt_q      <= '0;
      mismatch_cnt_q <= '0;
      error_q        <= 1'b0;
      error_addr_q   <= '0;
      err_seen_q     <= 1'b0;
      bist_fail_q    <= 1'b0;
    end else begin
      vld_q          <= vld_d;
      addr_q         <= addr_d;
      exp_q          <= exp_d;
      list_q         <= list_d;
      err_cnt_q      <= err_cnt_d;
      mismatch_cnt_q <= mismatch_cnt_d;
      error_q        <= error_d;
      error_addr_q   <= error_addr_d;
      err_seen_q     <= err_seen_d;
      bist_fail_q    <= bist_fail_d;
    end
  end

  assign bus.Error        = error_q;
  assign bus.ErrorAddr    = error_addr_q;
  assign bus.err_cnt      = err_cnt_q;
  assign bus.mismatch_cnt = mismatch_cnt_q;
  assign bus.err_seen     = err_seen_q;
  assign bus.bist_fail    = bist_fail_q;
endmodule

// File: tb/tb_mbist_err_capture.sv
// Bench for mbist_err_capture: one instance at read latency 1, one at 3,
// with a scoreboard of expected Error pulses checked every cycle.
module tb_mbist_err_capture;
  localparam int AW  = 9;
  localparam int DW  = 32;
  localparam int LIM = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mbist_err_capture_if #(.BIST_ADDR_WD(AW), .BIST_DATA_WD(DW)) if1 ();
  mbist_err_capture_if #(.BIST_ADDR_WD(AW), .BIST_DATA_WD(DW)) if3 ();

  mbist_err_capture #(.BIST_ADDR_WD(AW), .BIST_DATA_WD(DW),
                      .BIST_RD_LAT(1), .BIST_ERR_LIMIT(LIM))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  mbist_err_capture #(.BIST_ADDR_WD(AW), .BIST_DATA_WD(DW),
                      .BIST_RD_LAT(3), .BIST_ERR_LIMIT(LIM))
    dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));

  typedef struct {
    int            due;
    logic [AW-1:0] addr;
  } ev_t;

  ev_t sb1[$];
  ev_t sb3[$];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [AW-1:0] m_list [LIM];
  int            m_cnt = 0;
  logic [DW-1:0] dly1 [4];
  logic [DW-1:0] dly3 [4];

  task automatic model_clear1();
    m_cnt = 0;
    sb1.delete();
  endtask

  // Reference for the latency-1 instance: capture list decides whether a pulse is due.
  task automatic model1(input logic [AW-1:0] a, input bit bad);
    bit h;
    h = 1'b0;
    if (bad) begin
      for (int i = 0; i < m_cnt; i++) if (m_list[i] == a) h = 1'b1;
      if (!h && m_cnt < LIM) begin
        m_list[m_cnt] = a;
        m_cnt++;
        sb1.push_back('{cyc + 2, a});
      end
    end
  endtask

  task automatic step(input bit sel, input bit rd, input logic [AW-1:0] a,
                      input logic [DW-1:0] e, input logic [DW-1:0] rdat, input bit clr);
    @(negedge clk);
    for (int i = 3; i > 0; i--) begin
      dly1[i] = dly1[i-1];
      dly3[i] = dly3[i-1];
    end
    dly1[0] = sel ? '0 : rdat;
    dly3[0] = sel ? rdat : '0;
    if1.mem_rdata     = dly1[1];
    if3.mem_rdata     = dly3[3];
    if1.bist_rd       = rd && !sel;
    if1.bist_clear    = clr && !sel;
    if1.bist_addr     = a;
    if1.bist_exp_data = e;
    if3.bist_rd       = rd && sel;
    if3.bist_clear    = clr && sel;
    if3.bist_addr     = a;
    if3.bist_exp_data = e;
    if (clr) begin
      if (!sel) model_clear1();
      else sb3.delete();
    end else if (rd) begin
      if (!sel) model1(a, e !== rdat);
      else if (e !== rdat) sb3.push_back('{cyc + 4, a});
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, '0, '0, '0, 1'b0);
  endtask

  task automatic bad_rd(input bit sel, input logic [AW-1:0] a);
    logic [DW-1:0] e;
    e = $urandom;
    step(sel, 1'b1, a, e, e ^ (32'h1 << $urandom_range(31, 0)), 1'b0);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (sb1.size() > 0 && sb1[0].due == cyc) begin
        tests++;
        if (if1.Error !== 1'b1 || if1.ErrorAddr !== sb1[0].addr) begin
          fails++;
          $display("FAIL err_pulse_lat1 cyc=%0d got Error=%b ErrorAddr=%h want Error=1 ErrorAddr=%h",
                   cyc, if1.Error, if1.ErrorAddr, sb1[0].addr);
        end
        void'(sb1.pop_front());
      end else if (if1.Error !== 1'b0) begin
        tests++;
        fails++;
        $display("FAIL spurious_err_lat1 cyc=%0d got Error=%b want 0", cyc, if1.Error);
      end
      if (sb3.size() > 0 && sb3[0].due == cyc) begin
        tests++;
        if (if3.Error !== 1'b1 || if3.ErrorAddr !== sb3[0].addr) begin
          fails++;
          $display("FAIL err_pulse_lat3 cyc=%0d got Error=%b ErrorAddr=%h want Error=1 ErrorAddr=%h",
                   cyc, if3.Error, if3.ErrorAddr, sb3[0].addr);
        end
        void'(sb3.pop_front());
      end else if (if3.Error !== 1'b0) begin
        tests++;
        fails++;
        $display("FAIL spurious_err_lat3 cyc=%0d got Error=%b want 0", cyc, if3.Error);
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    idle(3);
    tests++;
    if ({if1.Error, if1.ErrorAddr, if1.err_cnt, if1.mismatch_cnt, if1.err_seen, if1.bist_fail,
         if3.Error, if3.err_cnt, if3.mismatch_cnt, if3.err_seen, if3.bist_fail} !== '0) begin
      fails++;
      $display("FAIL reset_state got cnt=%0d mism=%0d seen=%b fail=%b addr=%h want all 0",
               if1.err_cnt, if1.mismatch_cnt, if1.err_seen, if1.bist_fail, if1.ErrorAddr);
    end
    rst_n = 1'b1;
    model_clear1();
    sb3.delete();
  endtask

  task automatic test_all_pass();
    logic [DW-1:0] e;
    step(1'b0, 1'b0, '0, '0, '0, 1'b1);
    for (int i = 0; i < 16; i++) begin
      e = $urandom;
      step(1'b0, 1'b1, AW'(i), e, e, 1'b0);
    end
    idle(4);
    tests++;
    if ({if1.err_cnt, if1.mismatch_cnt, if1.err_seen, if1.bist_fail} !== {4'd0, 8'd0, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL all_pass got cnt=%0d mism=%0d seen=%b fail=%b want 0/0/0/0",
               if1.err_cnt, if1.mismatch_cnt, if1.err_seen, if1.bist_fail);
    end
  endtask

  task automatic test_single_mismatch();
    step(1'b0, 1'b0, '0, '0, '0, 1'b1);
    step(1'b0, 1'b1, 9'h023, 32'hA5A5A5A5, 32'hA5A5A5A4, 1'b0);
    idle(4);
    tests++;
    if ({if1.err_cnt, if1.mismatch_cnt, if1.err_seen, if1.bist_fail, if1.ErrorAddr}
        !== {4'd1, 8'd1, 1'b1, 1'b0, 9'h023}) begin
      fails++;
      $display("FAIL single_status got cnt=%0d mism=%0d seen=%b fail=%b addr=%h want 1/1/1/0 addr=023",
               if1.err_cnt, if1.mismatch_cnt, if1.err_seen, if1.bist_fail, if1.ErrorAddr);
    end
  endtask

  task automatic test_repeat_addr();
    step(1'b0, 1'b0, '0, '0, '0, 1'b1);
    bad_rd(1'b0, 9'h023);
    bad_rd(1'b0, 9'h023);
    idle(10);
    bad_rd(1'b0, 9'h023);
    idle(4);
    tests++;
    if ({if1.err_cnt, if1.mismatch_cnt, if1.err_seen, if1.bist_fail} !== {4'd1, 8'd3, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL repeat_status got cnt=%0d mism=%0d seen=%b fail=%b want 1/3/1/0",
               if1.err_cnt, if1.mismatch_cnt, if1.err_seen, if1.bist_fail);
    end
  endtask

  task automatic test_back_to_back_overflow();
    step(1'b0, 1'b0, '0, '0, '0, 1'b1);
    for (int i = 1; i <= 5; i++) bad_rd(1'b0, AW'(i));
    idle(4);
    tests++;
    if ({if1.err_cnt, if1.mismatch_cnt, if1.err_seen, if1.bist_fail} !== {4'd4, 8'd5, 1'b1, 1'b1}) begin
      fails++;
      $display("FAIL overflow_status got cnt=%0d mism=%0d seen=%b fail=%b want 4/5/1/1",
               if1.err_cnt, if1.mismatch_cnt, if1.err_seen, if1.bist_fail);
    end
    bad_rd(1'b0, 9'h003);
    idle(4);
    tests++;
    if ({if1.err_cnt, if1.mismatch_cnt, if1.bist_fail} !== {4'd4, 8'd6, 1'b1}) begin
      fails++;
      $display("FAIL overflow_hit got cnt=%0d mism=%0d fail=%b want 4/6/1",
               if1.err_cnt, if1.mismatch_cnt, if1.bist_fail);
    end
  endtask

  task automatic test_addr_zero();
    step(1'b0, 1'b0, '0, '0, '0, 1'b1);
    bad_rd(1'b0, 9'h000);
    bad_rd(1'b0, 9'h000);
    idle(4);
    tests++;
    if ({if1.err_cnt, if1.mismatch_cnt, if1.err_seen, if1.ErrorAddr} !== {4'd1, 8'd2, 1'b1, 9'h000}) begin
      fails++;
      $display("FAIL addr_zero got cnt=%0d mism=%0d seen=%b addr=%h want 1/2/1 addr=000",
               if1.err_cnt, if1.mismatch_cnt, if1.err_seen, if1.ErrorAddr);
    end
  endtask

  task automatic test_clear_priority();
    logic [DW-1:0] e;
    step(1'b0, 1'b0, '0, '0, '0, 1'b1);
    e = $urandom;
    step(1'b0, 1'b1, 9'h010, e, ~e, 1'b1);
    idle(4);
    tests++;
    if ({if1.err_cnt, if1.mismatch_cnt, if1.err_seen, if1.bist_fail} !== '0) begin
      fails++;
      $display("FAIL clear_priority got cnt=%0d mism=%0d seen=%b fail=%b want 0/0/0/0",
               if1.err_cnt, if1.mismatch_cnt, if1.err_seen, if1.bist_fail);
    end
  endtask

  task automatic test_saturation();
    step(1'b0, 1'b0, '0, '0, '0, 1'b1);
    for (int i = 0; i < 300; i++) bad_rd(1'b0, 9'h055);
    idle(4);
    tests++;
    if ({if1.err_cnt, if1.mismatch_cnt, if1.err_seen, if1.bist_fail} !== {4'd1, 8'd255, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL saturation got cnt=%0d mism=%0d seen=%b fail=%b want 1/255/1/0",
               if1.err_cnt, if1.mismatch_cnt, if1.err_seen, if1.bist_fail);
    end
  endtask

  task automatic test_lat3();
    step(1'b1, 1'b0, '0, '0, '0, 1'b1);
    bad_rd(1'b1, 9'h1F0);
    idle(8);
    tests++;
    if ({if3.err_cnt, if3.mismatch_cnt, if3.err_seen, if3.ErrorAddr} !== {4'd1, 8'd1, 1'b1, 9'h1F0}) begin
      fails++;
      $display("FAIL lat3_detect got cnt=%0d mism=%0d seen=%b addr=%h want 1/1/1 addr=1F0",
               if3.err_cnt, if3.mismatch_cnt, if3.err_seen, if3.ErrorAddr);
    end
    // In-flight mismatch, clear two cycles after the read.
    step(1'b1, 1'b0, '0, '0, '0, 1'b1);
    bad_rd(1'b1, 9'h1F0);
    idle(1);
    step(1'b1, 1'b0, '0, '0, '0, 1'b1);
    idle(8);
    tests++;
    if ({if3.err_cnt, if3.mismatch_cnt, if3.err_seen, if3.bist_fail} !== '0) begin
      fails++;
      $display("FAIL lat3_clear got cnt=%0d mism=%0d seen=%b fail=%b want 0/0/0/0",
               if3.err_cnt, if3.mismatch_cnt, if3.err_seen, if3.bist_fail);
    end
    bad_rd(1'b1, 9'h1F0);
    idle(2);
    rst_n = 1'b0;
    model_clear1();
    sb3.delete();
    idle(1);
    rst_n = 1'b1;
    idle(8);
    tests++;
    if ({if3.err_cnt, if3.mismatch_cnt, if3.err_seen, if3.bist_fail} !== '0) begin
      fails++;
      $display("FAIL lat3_reset got cnt=%0d mism=%0d seen=%b fail=%b want 0/0/0/0",
               if3.err_cnt, if3.mismatch_cnt, if3.err_seen, if3.bist_fail);
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      dly1[i] = '0;
      dly3[i] = '0;
    end
    {if1.bist_clear, if1.bist_rd, if1.bist_addr, if1.bist_exp_data, if1.mem_rdata} = '0;
    {if3.bist_clear, if3.bist_rd, if3.bist_addr, if3.bist_exp_data, if3.mem_rdata} = '0;
    test_reset();
    test_all_pass();
    test_single_mismatch();
    test_repeat_addr();
    test_back_to_back_overflow();
    test_addr_zero();
    test_clear_priority();
    test_saturation();
    test_lat3();
    idle(6);
    tests++;
    if (sb1.size() != 0 || sb3.size() != 0) begin
      fails++;
      $display("FAIL pending_pulses got %0d/%0d outstanding want 0/0", sb1.size(), sb3.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
